// File: rtl/verinject_pkg.sv
`default_nettype none
// =============================================================================
// verinject_pkg: shared types and constants for the fault scheduler slice.
// Rev 1.0
// =============================================================================
package verinject_pkg;

  localparam logic [31:0] NO_INJECT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] bit_idx;
  } event_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/verinject_event_fifo.sv
`default_nettype none
// =============================================================================
// verinject_event_fifo: FIFO of {cycle, bit} events with fall-through head.
// Rev 1.0
// =============================================================================
module verinject_event_fifo
  import verinject_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  event_t push_data,
  output logic   full,
  output logic   empty,
  output event_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  event_t      r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign head  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clock) begin
    if (push && !full) begin
      r_mem[r_wr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (clear) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push && !full) r_wr <= r_wr + PTR_ONE;
      if (pop && !empty) r_rd <= r_rd + PTR_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/verinject_fault_scheduler.sv
`default_nettype none
// =============================================================================
// verinject_fault_scheduler: drives queued bit indices onto the injector bus
// when the enabled-cycle counter reaches each event's trigger cycle.
// Rev 1.0
// =============================================================================
module verinject_fault_scheduler
  import verinject_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int PULSE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_cycle,
  input  logic [31:0] push_bit,
  output logic [31:0] verinject__injector_state,
  output logic        busy,
  output logic [15:0] fired_count,
  output logic [15:0] late_count
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_ONE  = 1;

  state_t        r_state;
  logic [31:0]   r_cyc;
  logic [31:0]   r_bus;
  logic [PW-1:0] r_pulse;
  logic [15:0]   r_fired;
  logic [15:0]   r_late;

  event_t w_push_evt;
  event_t w_head;
  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;

  assign w_push_evt = '{cycle: push_cycle, bit_idx: push_bit};
  assign w_push     = push_valid && !w_full && !clear;
  assign w_pop      = (r_state == ST_WAIT) && enable && (r_cyc >= w_head.cycle) && !clear;

  assign push_ready                = !w_full;
  assign busy                      = (r_state != ST_IDLE);
  assign verinject__injector_state = r_bus;
  assign fired_count               = r_fired;
  assign late_count                = r_late;

  verinject_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_push_evt),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc <= '0;
    end else if (clear) begin
      r_cyc <= '0;
    end else if (enable && (r_cyc != 32'hFFFF_FFFF)) begin
      r_cyc <= r_cyc + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_bus   <= NO_INJECT;
      r_pulse <= '0;
      r_fired <= '0;
      r_late  <= '0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_bus   <= NO_INJECT;
      r_pulse <= '0;
      r_fired <= '0;
      r_late  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_pop) begin
            r_state <= ST_FIRE;
            r_bus   <= w_head.bit_idx;
            r_pulse <= PULSE_LAST;
            r_fired <= sat_inc16(r_fired);
            if (r_cyc > w_head.cycle) r_late <= sat_inc16(r_late);
          end
        end
        ST_FIRE: begin
          // Pulse runs to completion independent of enable.
          if (r_pulse == '0) begin
            r_bus   <= NO_INJECT;
            r_state <= w_empty ? ST_IDLE : ST_WAIT;
          end else begin
            r_pulse <= r_pulse - PULSE_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_verinject_fault_scheduler.sv
`default_nettype none
// =============================================================================
// tb_verinject_fault_scheduler: directed bench driving a PULSE_CYCLES=1 and a
// PULSE_CYCLES=3 scheduler with shared stimulus.
// Rev 1.0
// =============================================================================
module tb_verinject_fault_scheduler;

  localparam logic [31:0] NO = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n, enable, clear, push_valid;
  logic [31:0] push_cycle, push_bit;
  logic        ready1, ready3, busy1, busy3;
  logic [31:0] bus1, bus3;
  logic [15:0] fired1, fired3, late1, late3;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] seen1[$];
  logic [31:0] seen3[$];
  logic [31:0] prev1, prev3;

  always #5 clock = ~clock;

  verinject_fault_scheduler #(.DEPTH(4), .PULSE_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
    .push_valid(push_valid), .push_ready(ready1), .push_cycle(push_cycle),
    .push_bit(push_bit), .verinject__injector_state(bus1), .busy(busy1),
    .fired_count(fired1), .late_count(late1)
  );

  verinject_fault_scheduler #(.DEPTH(4), .PULSE_CYCLES(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
    .push_valid(push_valid), .push_ready(ready3), .push_cycle(push_cycle),
    .push_bit(push_bit), .verinject__injector_state(bus3), .busy(busy3),
    .fired_count(fired3), .late_count(late3)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [31:0] e1, input logic [31:0] e3);
    tick();
    check_vec({tag, "_bus1"}, bus1, e1);
    check_vec({tag, "_bus3"}, bus3, e3);
  endtask

  task automatic offer(input logic [31:0] c, input logic [31:0] b);
    push_valid = 1'b1;
    push_cycle = c;
    push_bit   = b;
  endtask

  task automatic do_clear();
    enable     = 1'b0;
    push_valid = 1'b0;
    clear      = 1'b1;
    tick();
    clear      = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [31:0] f1, input logic [31:0] l1,
                              input logic [31:0] f3, input logic [31:0] l3, input logic [31:0] bz);
    check_vec({tag, "_fired1"}, {16'd0, fired1}, f1);
    check_vec({tag, "_late1"},  {16'd0, late1},  l1);
    check_vec({tag, "_fired3"}, {16'd0, fired3}, f3);
    check_vec({tag, "_late3"},  {16'd0, late3},  l3);
    check_vec({tag, "_busy1"},  {31'd0, busy1},  bz);
    check_vec({tag, "_busy3"},  {31'd0, busy3},  bz);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; push_valid = 1'b0;
    push_cycle = '0; push_bit = '0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset values
    check_vec("rst_bus1", bus1, NO);
    check_vec("rst_bus3", bus3, NO);
    check_vec("rst_ready1", {31'd0, ready1}, 1);
    check_vec("rst_ready3", {31'd0, ready3}, 1);
    check_status("rst", 0, 0, 0, 0, 0);

    // Single event {10,5} with enable from reset: fires on the edge where cyc==10
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) begin offer(10, 5); enable = 1'b1; end
      if (k == 2) push_valid = 1'b0;
      step_chk("a", (k == 11) ? 32'd5 : NO, (k >= 11 && k <= 13) ? 32'd5 : NO);
    end
    check_status("a", 1, 0, 1, 0, 0);

    // Two events at equal cycle 4; the second is late
    do_clear();
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) offer(4, 7);
      if (k == 2) offer(4, 9);
      if (k == 3) begin push_valid = 1'b0; enable = 1'b1; end
      step_chk("b",
               (k == 7) ? 32'd7 : (k == 9) ? 32'd9 : NO,
               (k >= 7 && k <= 9) ? 32'd7 : (k >= 11 && k <= 13) ? 32'd9 : NO);
    end
    check_status("b", 2, 1, 2, 1, 0);

    // Fill queue with enable low; fifth push must be dropped
    do_clear();
    for (int k = 1; k <= 5; k++) begin
      offer(k, 99 + k);
      tick();
      if (k == 4) begin
        check_vec("c_full_ready1", {31'd0, ready1}, 0);
        check_vec("c_full_ready3", {31'd0, ready3}, 0);
      end
    end
    push_valid = 1'b0;
    check_vec("c_ready1", {31'd0, ready1}, 0);
    check_vec("c_ready3", {31'd0, ready3}, 0);
    enable = 1'b1;
    prev1 = bus1; prev3 = bus3;
    seen1.delete(); seen3.delete();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus1 != NO && prev1 == NO) seen1.push_back(bus1);
      if (bus3 != NO && prev3 == NO) seen3.push_back(bus3);
      prev1 = bus1; prev3 = bus3;
    end
    check_vec("c_n1", seen1.size(), 4);
    check_vec("c_n3", seen3.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_vec("c_ord1", (i < seen1.size()) ? seen1[i] : NO, 100 + i);
      check_vec("c_ord3", (i < seen3.size()) ? seen3[i] : NO, 100 + i);
    end
    check_vec("c_fired1", {16'd0, fired1}, 4);
    check_vec("c_fired3", {16'd0, fired3}, 4);
    check_vec("c_ready_after", {31'd0, ready3}, 1);

    // Enable dropped mid-pulse: pulse completes, cyc frozen at 4, second event waits
    do_clear();
    for (int k = 1; k <= 18; k++) begin
      if (k == 1) offer(3, 50);
      if (k == 2) offer(4, 60);
      if (k == 3) begin push_valid = 1'b0; enable = 1'b1; end
      if (k == 7) enable = 1'b0;
      if (k == 13) enable = 1'b1;
      step_chk("d",
               (k == 6) ? 32'd50 : (k == 13) ? 32'd60 : NO,
               (k >= 6 && k <= 8) ? 32'd50 : (k >= 13 && k <= 15) ? 32'd60 : NO);
      if (k == 10) begin
        check_vec("d_busy1_hold", {31'd0, busy1}, 1);
        check_vec("d_busy3_hold", {31'd0, busy3}, 1);
      end
    end
    check_status("d", 2, 0, 2, 0, 0);

    // Clear during FIRE with a pending event and a simultaneous push
    do_clear();
    for (int k = 1; k <= 3; k++) begin
      if (k == 1) begin offer(0, 77); enable = 1'b1; end
      if (k == 2) offer(0, 88);
      if (k == 3) push_valid = 1'b0;
      step_chk("e", (k == 3) ? 32'd77 : NO, (k == 3) ? 32'd77 : NO);
    end
    clear = 1'b1;
    offer(0, 99);
    step_chk("e_clr", NO, NO);
    check_status("e_clr", 0, 0, 0, 0, 0);
    check_vec("e_ready3", {31'd0, ready3}, 1);
    clear = 1'b0; push_valid = 1'b0;
    for (int k = 0; k < 8; k++) step_chk("e_post", NO, NO);
    check_status("e_post", 0, 0, 0, 0, 0);

    // Asynchronous reset mid-pulse
    do_clear();
    for (int k = 1; k <= 3; k++) begin
      if (k == 1) begin offer(0, 33); enable = 1'b1; end
      if (k == 2) push_valid = 1'b0;
      step_chk("f", (k == 3) ? 32'd33 : NO, (k == 3) ? 32'd33 : NO);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_vec("f_async_bus1", bus1, NO);
    check_vec("f_async_bus3", bus3, NO);
    check_status("f_async", 0, 0, 0, 0, 0);
    check_vec("f_ready1", {31'd0, ready1}, 1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) step_chk("f_post", NO, NO);
    check_status("f_post", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/verinject_fault_scheduler.md
# verinject_fault_scheduler

Time-driven sequencer for the `verinject__injector_state` bus that every `verinject_ff_injector` instance in a design decodes. A testbench or host loads a small queue of (trigger cycle, global bit index) events. The block counts enabled clock cycles and, when an event's trigger cycle is reached, drives that bit index onto the bus for a configurable pulse width. The rest of the time it holds the bus at the no-injection value, so that one scheduler can sequence single- and multi-bit upsets across the whole flop population.

## Interface
- `DEPTH`, default 4: event queue entries; power of two, at least 2.
- `PULSE_CYCLES`, default 1: cycles each event's bit index is held on the bus; at least 1.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  run; cycle counter advances and events may fire only while high.
- `clear`  in  1  synchronous flush; overrides all other inputs.
- `push_valid`  in  1  event offered.
- `push_ready`  out  1  queue can accept; high iff not full.
- `push_cycle`  in  32  trigger cycle of the offered event.
- `push_bit`  in  32  global bit index of the offered event (P_START-space).
- `verinject__injector_state`  out  32  registered injector bus.
- `busy`  out  1  queue non-empty or pulse in progress.
- `fired_count`  out  16  events fired since reset/clear; saturates at 0xFFFF.
- `late_count`  out  16  events fired after their trigger cycle; saturates at 0xFFFF.

## Operation
- `NO_INJECT` is 32'hFFFF_FFFF. It must lie outside every injector's range, so the design's total injectable bits are below 2^32−1.
- Cycle counter `cyc` (32 bit):
  - Increments each edge while `enable`=1.
  - Saturates at 0xFFFF_FFFF.
  - Holds while `enable`=0.
- Queue:
  - FIFO of {cycle, bit}. A push is accepted on an edge with `push_valid`&&`push_ready`.
  - `push_ready` depends only on the current occupancy. When full it is 0, even if a pop happens on the same edge.
  - Events are expected in nondecreasing `push_cycle` order. The block does not reorder them.
- FSM states: IDLE, WAIT, FIRE.
  - IDLE to WAIT when the queue is non-empty.
  - WAIT to FIRE on an edge where `enable`=1 and `cyc` >= head.cycle. On that edge:
    - the head is popped;
    - `verinject__injector_state` is set to head.bit;
    - the pulse counter is set to PULSE_CYCLES−1;
    - `fired_count` increments;
    - `late_count` also increments if `cyc` > head.cycle.
  - FIRE: the pulse counter decrements each edge regardless of `enable`, so a pulse always completes. When it is 0, the next edge sets the bus to `NO_INJECT` and goes to WAIT if the queue is non-empty, otherwise IDLE.
  - Back-to-back events are separated by at least one `NO_INJECT` cycle.
- `clear`=1 on an edge does all of the following:
  - empties the queue;
  - zeroes `cyc`, `fired_count` and `late_count`;
  - forces the bus to `NO_INJECT`;
  - sets the state to IDLE;
  - ignores a simultaneous push.
- `busy` = (state≠IDLE).

## Timing
- Reset values:
  - `verinject__injector_state` = 0xFFFF_FFFF;
  - `push_ready` = 1;
  - `busy` = 0;
  - `fired_count` = `late_count` = 0;
  - `cyc` = 0; queue empty; state IDLE.
- `reset_n` falling mid-pulse returns the bus to `NO_INJECT` immediately (asynchronous reset), without waiting for a clock edge.
- A pushed event is visible at the queue head the edge after acceptance. WAIT is entered one edge later.
- Fire latency: if `cyc`==N in the cycle the FSM first sees WAIT with head.cycle=N, the bus shows the bit from the following cycle for exactly PULSE_CYCLES cycles.
- An event pushed with a cycle already passed fires on the first WAIT evaluation and is counted late.
- Two events with equal cycle: the second fires late, PULSE_CYCLES+1 cycles after the first, and is counted in `late_count`.

## Structure
- Shared package `verinject_pkg`: `NO_INJECT` constant, event struct {cycle[31:0], bit[31:0]}, FSM state enum.
- Sub-module `verinject_event_fifo` (parameter DEPTH; push/pop/full/empty/head) holds the queue. FSM, counters and bus register live in the top.

## Test plan
- Reset: bus=0xFFFF_FFFF, `push_ready`=1, `busy`=0, both counts 0.
- Push {10, 5}, `enable`=1 from reset → bus=5 in exactly one cycle after `cyc`==10, 0xFFFF_FFFF otherwise; `fired_count`=1, `late_count`=0.
- PULSE_CYCLES=3, push {4,7},{4,9} → bus=7 for 3 cycles, one `NO_INJECT` cycle, bus=9 for 3 cycles; `late_count`=1.
- Fill DEPTH=4 queue while `enable`=0 → `push_ready`=0, 5th push ignored; `enable` high fires exactly 4 events in order.
- `enable` dropped mid-pulse → pulse completes; `cyc` frozen; the next event does not fire until `enable` returns.
- `clear` during FIRE and `reset_n` low mid-pulse → bus=0xFFFF_FFFF; queue empty; counts 0; `busy`=0.
